// File: rtl/axi_line_refill_master.sv
// AXI4 read-only burst master: one cache-line refill at a time, one INCR burst per line,
// returned beats gathered into a line buffer and handed back with a sticky error flag.
module axi_line_refill_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [DATA_WIDTH*LINE_WORDS-1:0] resp_data,
    output logic                             resp_err,
    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arlock,
    output logic [3:0]                       m_axi_arcache,
    output logic [2:0]                       m_axi_arprot,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [ID_WIDTH-1:0]              m_axi_rid,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
);

    localparam int unsigned LINE_W = DATA_WIDTH * LINE_WORDS;
    localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [LINE_W-1:0]       buf_q, buf_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, arvalid_q, rready_q, resp_valid_q;
    logic                    last_cnt;

    assign last_cnt = (cnt_q == LAST_CNT);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        buf_d    = buf_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    araddr_d = req_addr & ALIGN_MASK;
                    buf_d    = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                        if (CNT_W'(i) == cnt_q) begin
                            buf_d[i*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    // Early or missing RLAST is a protocol error; the counted last beat always ends the burst
                    err_d = err_q | (m_axi_rresp != 2'b00) | (m_axi_rid != ID_WIDTH'(AXI_ID))
                          | (m_axi_rlast != last_cnt);
                    if (m_axi_rlast || last_cnt) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            buf_q        <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            buf_q        <= buf_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == S_IDLE);
            arvalid_q    <= (state_d == S_AR);
            rready_q     <= (state_d == S_R);
            resp_valid_q <= (state_d == S_RESP);
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = buf_q;
    assign resp_err      = err_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_araddr  = araddr_q;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_axi_line_refill_master.sv
// Bench for axi_line_refill_master: behavioural AXI RAM slave with fault knobs and a response scoreboard.
module tb_axi_line_refill_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_addr = '0;
    logic resp_valid, resp_ready = 1'b0;
    logic [DW*LW-1:0] resp_data;
    logic resp_err;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst;
    logic arlock, arvalid, arready = 1'b0;
    logic [3:0] arcache;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0] rresp = '0;
    logic rlast = 1'b0, rvalid = 1'b0, rready;

    axi_line_refill_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                             .LINE_WORDS(LW), .AXI_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input int idx);
        return 32'(idx) * 32'h0101_0101 + 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            stall;
        int            err_beat;
        int            last_beat;
        int            badid_beat;
        int            nolast;
        logic [AW-1:0] exp_araddr;
        logic          exp_err;
        int            exp_beats;
    } vec_t;

    typedef struct {
        logic [DW*LW-1:0] data;
        logic             err;
        logic [AW-1:0]    araddr;
        int               stall;
        int               ar_before;
    } exp_t;

    exp_t sb[$];

    // Slave configuration and handshake bookkeeping
    int cfg_stall = 0, cfg_err_beat = -1, cfg_last_beat = -1, cfg_badid_beat = -1, cfg_nolast = 0;
    int stall_left = 0, beat = 0, cyc = 0, last_r_cyc = 0, ar_count = 0;
    bit ar_started = 0, active = 0, ar_hs = 0, r_hs = 0;
    logic [AW-1:0] base = '0, ar_cap = '0;

    always @(posedge clk) begin
        cyc++;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (ar_hs) begin
            ar_count++;
            ar_cap = araddr;
        end
        if (r_hs) last_r_cyc = cyc;
    end

    // AXI RAM slave, driven on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            active = 0; ar_started = 0; beat = 0;
        end else begin
            if (ar_hs) begin
                active = 1; base = ar_cap; beat = 0; ar_started = 0;
            end
            if (r_hs) begin
                if (rlast || beat == LW - 1) active = 0;
                beat++;
            end
            arready = 1'b0;
            if (arvalid && !active) begin
                if (!ar_started) begin
                    ar_started = 1;
                    stall_left = cfg_stall;
                end
                if (stall_left > 0) stall_left--;
                else arready = 1'b1;
            end
            if (active) begin
                rvalid = 1'b1;
                rid    = (beat == cfg_badid_beat) ? 8'h5A : 8'h00;
                rdata  = mem_word(int'(base >> 2) + beat);
                rresp  = (beat == cfg_err_beat) ? 2'b10 : 2'b00;
                rlast  = ((beat == LW - 1) && (cfg_nolast == 0)) || (beat == cfg_last_beat);
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        cfg_stall = v.stall; cfg_err_beat = v.err_beat; cfg_last_beat = v.last_beat;
        cfg_badid_beat = v.badid_beat; cfg_nolast = v.nolast;
        e.data = '0;
        for (int i = 0; i < v.exp_beats; i++)
            e.data[i*DW +: DW] = mem_word(int'(v.exp_araddr) / 4 + i);
        e.err = v.exp_err;
        e.araddr = v.exp_araddr;
        e.stall = v.stall;
        e.ar_before = ar_count;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic [AW-1:0] a);
        int t = 0;
        req_addr = a;
        req_valid = 1'b1;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("req accepted", 64'(req_ready), 64'(1));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_resp(input string nm, input int hold);
        exp_t e;
        int t = 0, bad_ar = 0, av = 0, bad_hold = 0;
        logic [DW*LW-1:0] snap;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", nm);
            return;
        end
        e = sb.pop_front();
        while (!resp_valid && t < 1000) begin
            if (arvalid) begin
                av++;
                if (araddr !== e.araddr) bad_ar++;
            end
            @(negedge clk);
            t++;
        end
        check({nm, " resp_valid"}, 64'(resp_valid), 64'(1));
        check({nm, " araddr unstable cycles"}, 64'(bad_ar), 64'(0));
        check({nm, " arvalid cycles"}, 64'(av), 64'(e.stall + 1));
        check({nm, " AR handshakes"}, 64'(ar_count - e.ar_before), 64'(1));
        check({nm, " araddr"}, 64'(ar_cap), 64'(e.araddr));
        check({nm, " resp latency"}, 64'(cyc - last_r_cyc), 64'(0));
        check({nm, " resp_err"}, 64'(resp_err), 64'(e.err));
        for (int i = 0; i < LW; i++)
            check($sformatf("%s word%0d", nm, i), 64'(resp_data[i*DW +: DW]), 64'(e.data[i*DW +: DW]));
        snap = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== snap || req_ready || arvalid) bad_hold++;
        end
        if (hold > 0) check({nm, " hold violations"}, 64'(bad_hold), 64'(0));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({nm, " resp_valid dropped"}, 64'(resp_valid), 64'(0));
        check({nm, " req_ready after resp"}, 64'(req_ready), 64'(1));
    endtask

    vec_t vecs[7];

    initial begin
        int t;
        vec_t v;
        vecs[0] = '{16'h0024, 0, -1, -1, -1, 0, 16'h0020, 1'b0, 8};
        vecs[1] = '{16'h0024, 5, -1, -1, -1, 0, 16'h0020, 1'b0, 8};
        vecs[2] = '{16'h0100, 0,  3, -1, -1, 0, 16'h0100, 1'b1, 8};
        vecs[3] = '{16'h006C, 0, -1,  5, -1, 0, 16'h0060, 1'b1, 6};
        vecs[4] = '{16'hFFFF, 2, -1, -1, -1, 0, 16'hFFE0, 1'b0, 8};
        vecs[5] = '{16'h013C, 0, -1, -1,  7, 0, 16'h0120, 1'b1, 8};
        vecs[6] = '{16'h0201, 0, -1,  0, -1, 0, 16'h0200, 1'b1, 1};

        #2 rst_n = 1'b0;
        #1;
        check("reset req_ready", 64'(req_ready), 64'(1));
        check("reset arvalid", 64'(arvalid), 64'(0));
        check("reset rready", 64'(rready), 64'(0));
        check("reset resp_valid", 64'(resp_valid), 64'(0));
        check("reset resp_err", 64'(resp_err), 64'(0));
        check("reset araddr", 64'(araddr), 64'(0));
        check("reset resp_data", 64'(resp_data == '0), 64'(1));
        check("arlen", 64'(arlen), 64'(7));
        check("arsize", 64'(arsize), 64'(2));
        check("arburst", 64'(arburst), 64'(1));
        check("arid", 64'(arid), 64'(0));
        check("arlock/cache/prot", 64'({arlock, arcache, arprot}), 64'({1'b0, 4'b0011, 3'b000}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready after release", 64'(req_ready), 64'(1));

        for (int i = 0; i < 7; i++) begin
            push_exp(vecs[i]);
            drive_req(vecs[i].addr);
            finish_resp($sformatf("vec%0d", i), 0);
        end

        // Missing RLAST on the final beat still ends the burst but flags an error
        v = '{16'h0300, 0, -1, -1, -1, 1, 16'h0300, 1'b1, 8};
        push_exp(v);
        drive_req(v.addr);
        finish_resp("nolast", 0);

        // Response backpressure with a second request waiting
        v = '{16'h0024, 0, -1, -1, -1, 0, 16'h0020, 1'b0, 8};
        push_exp(v);
        drive_req(v.addr);
        req_addr = 16'h0048;
        req_valid = 1'b1;
        finish_resp("backpressure", 10);
        v = '{16'h0048, 0, -1, -1, -1, 0, 16'h0040, 1'b0, 8};
        push_exp(v);
        @(negedge clk);
        check("second request accepted next cycle", 64'(arvalid), 64'(1));
        req_valid = 1'b0;
        finish_resp("second", 0);

        // Reset during beat 4 discards the partial line
        cfg_stall = 0; cfg_err_beat = -1; cfg_last_beat = -1; cfg_badid_beat = -1; cfg_nolast = 0;
        drive_req(16'h0080);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(active && beat == 4) && t < 100);
        check("reached beat 4", 64'(beat), 64'(4));
        rst_n = 1'b0;
        #1;
        check("midreset arvalid", 64'(arvalid), 64'(0));
        check("midreset rready", 64'(rready), 64'(0));
        check("midreset resp_valid", 64'(resp_valid), 64'(0));
        check("midreset req_ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("req_ready after midreset", 64'(req_ready), 64'(1));
        v = '{16'h0040, 0, -1, -1, -1, 0, 16'h0040, 1'b0, 8};
        push_exp(v);
        drive_req(v.addr);
        finish_resp("post-reset", 0);

        check("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
